// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - data-memory initiator: lb/lh/lw/lbu/lhu loads, sw direct and sb/sh read-modify-write stores
module load_store_unit #(
  parameter int MEM_BYTES = 32
) (
  input  logic        clk_i,
  input  logic        reset,
  input  logic        req_i,
  output logic        ready_o,
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_write_o,
  output logic        mem_read_o,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [31:0] LAST_ADDR = 32'(MEM_BYTES - 4);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      r_state;
  logic        r_is_store;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  logic        w_bad_funct3;
  logic        w_illegal;
  logic        w_direct_write;
  logic [31:0] w_load_data;
  logic [31:0] w_merge_data;

  always_comb begin
    w_bad_funct3 = 1'b0;
    if (is_store_i)
      w_bad_funct3 = !(funct3_i == 3'b000 || funct3_i == 3'b001 || funct3_i == 3'b010);
    else
      w_bad_funct3 = (funct3_i == 3'b011 || funct3_i == 3'b110 || funct3_i == 3'b111);
  end

  // Unsigned compare also rejects wrap-around addresses near 2^32.
  assign w_illegal      = w_bad_funct3 || (addr_i > LAST_ADDR);
  assign w_direct_write = is_store_i && (funct3_i == 3'b010);
  assign ready_o        = (r_state == IDLE);

  always_comb begin
    case (r_funct3)
      3'b000:  w_load_data = {{24{mem_rdata_i[7]}}, mem_rdata_i[7:0]};
      3'b001:  w_load_data = {{16{mem_rdata_i[15]}}, mem_rdata_i[15:0]};
      3'b100:  w_load_data = {24'h0, mem_rdata_i[7:0]};
      3'b101:  w_load_data = {16'h0, mem_rdata_i[15:0]};
      default: w_load_data = mem_rdata_i;
    endcase
  end

  // Sub-word stores keep the upper bytes of the word read in READ.
  always_comb begin
    case (r_funct3)
      3'b000:  w_merge_data = {mem_rdata_i[31:8], r_wdata[7:0]};
      3'b001:  w_merge_data = {mem_rdata_i[31:16], r_wdata[15:0]};
      default: w_merge_data = r_wdata;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_is_store  <= 1'b0;
      r_funct3    <= 3'b000;
      r_addr      <= 32'h0;
      r_wdata     <= 32'h0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      rdata_o     <= 32'h0;
      mem_addr_o  <= 32'h0;
      mem_wdata_o <= 32'h0;
      mem_write_o <= 1'b0;
      mem_read_o  <= 1'b0;
    end else begin
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      mem_addr_o  <= 32'h0;
      mem_wdata_o <= 32'h0;
      mem_write_o <= 1'b0;
      mem_read_o  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_i) begin
            r_is_store <= is_store_i;
            r_funct3   <= funct3_i;
            r_addr     <= addr_i;
            r_wdata    <= wdata_i;
            if (w_illegal) begin
              r_state <= RESP;
              done_o  <= 1'b1;
              err_o   <= 1'b1;
              rdata_o <= 32'h0;
            end else if (w_direct_write) begin
              r_state     <= WRITE;
              mem_write_o <= 1'b1;
              mem_addr_o  <= addr_i;
              mem_wdata_o <= wdata_i;
            end else begin
              r_state    <= READ;
              mem_read_o <= 1'b1;
              mem_addr_o <= addr_i;
            end
          end
        end
        READ: begin
          if (r_is_store) begin
            r_state     <= WRITE;
            mem_write_o <= 1'b1;
            mem_addr_o  <= r_addr;
            mem_wdata_o <= w_merge_data;
          end else begin
            r_state <= RESP;
            done_o  <= 1'b1;
            rdata_o <= w_load_data;
          end
        end
        WRITE: begin
          r_state <= RESP;
          done_o  <= 1'b1;
          rdata_o <= 32'h0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed and randomized checks of load_store_unit against a byte-array reference model
module tb_load_store_unit;

  localparam int MEM_BYTES = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_i = 1'b0;
  logic        is_store_i = 1'b0;
  logic [2:0]  funct3_i = 3'b000;
  logic [31:0] addr_i = 32'h0;
  logic [31:0] wdata_i = 32'h0;
  logic        ready_o, done_o, err_o, mem_write_o, mem_read_o;
  logic [31:0] rdata_o, mem_addr_o, mem_wdata_o;
  logic [31:0] mem_rdata_i;

  logic [7:0]  mem      [MEM_BYTES];
  logic [7:0]  init_mem [MEM_BYTES];
  logic [7:0]  ref_mem  [MEM_BYTES];
  logic        load_mem = 1'b0;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_rdata = 32'h0;
  bit          b2b_pending = 1'b0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk_i       (clk),
    .reset       (reset),
    .req_i       (req_i),
    .ready_o     (ready_o),
    .is_store_i  (is_store_i),
    .funct3_i    (funct3_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .done_o      (done_o),
    .err_o       (err_o),
    .rdata_o     (rdata_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_write_o (mem_write_o),
    .mem_read_o  (mem_read_o),
    .mem_rdata_i (mem_rdata_i)
  );

  // Data memory seen by the DUT: combinational read, write on the clock edge.
  always_comb begin
    mem_rdata_i = 32'h0;
    if (mem_addr_o <= 32'(MEM_BYTES - 4))
      for (int k = 0; k < 4; k++) mem_rdata_i[8*k +: 8] = mem[mem_addr_o[4:0] + 5'(k)];
  end

  always @(posedge clk) begin
    if (load_mem) begin
      for (int k = 0; k < MEM_BYTES; k++) mem[k] <= init_mem[k];
    end else if (mem_write_o && mem_addr_o <= 32'(MEM_BYTES - 4)) begin
      for (int k = 0; k < 4; k++) mem[mem_addr_o[4:0] + 5'(k)] <= mem_wdata_o[8*k +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = ref_mem[a[4:0] + 5'(k)];
    return r;
  endfunction

  function automatic logic [31:0] dut_word(input int w);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = mem[5'(4*w + k)];
    return r;
  endfunction

  task automatic chk_mem(input string tag);
    for (int w = 0; w < MEM_BYTES / 4; w++)
      chk($sformatf("%s_mem%0d", tag, w), dut_word(w), ref_word(32'(4 * w)));
  endtask

  task automatic do_op(input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input bit b2b, input string tag);
    bit          err;
    int          lat, ex_reads, ex_writes, n, reads, writes, w;
    bit          got_done;
    logic [31:0] word, new_rdata, ex_wword;
    logic [7:0]  b;
    logic [15:0] h;
    int          nbytes;

    word      = ref_word(a);
    new_rdata = 32'h0;
    ex_wword  = 32'h0;
    err = (st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6)) || (a > 32'(MEM_BYTES - 4));
    if (err) begin
      lat = 1; ex_reads = 0; ex_writes = 0;
    end else if (!st) begin
      lat = 2; ex_reads = 1; ex_writes = 0;
      b = word[7:0];
      h = word[15:0];
      case (f3)
        3'd0:    new_rdata = (b >= 8'd128) ? 32'(b) - 32'd256 : 32'(b);
        3'd1:    new_rdata = (h >= 16'd32768) ? 32'(h) - 32'h10000 : 32'(h);
        3'd4:    new_rdata = word % 32'd256;
        3'd5:    new_rdata = word % 32'h10000;
        default: new_rdata = word;
      endcase
    end else begin
      nbytes = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
      for (int k = 0; k < nbytes; k++) ref_mem[a[4:0] + 5'(k)] = wd[8*k +: 8];
      ex_wword  = ref_word(a);
      lat       = (f3 == 3'd2) ? 2 : 3;
      ex_reads  = (f3 == 3'd2) ? 0 : 1;
      ex_writes = 1;
    end

    is_store_i = st; funct3_i = f3; addr_i = a; wdata_i = wd; req_i = 1'b1;
    w = 0;
    while (!ready_o && w < 4) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_acc_wait"}, w, b2b ? 32'd1 : 32'd0);
    chk({tag, "_rdata_hold"}, rdata_o, exp_rdata);
    @(posedge clk);
    #1;
    n = 0; reads = 0; writes = 0; got_done = 1'b0;
    while (n < 8 && !got_done) begin
      @(negedge clk);
      n++;
      chk({tag, "_excl"}, 32'(mem_read_o & mem_write_o), 32'd0);
      if (mem_read_o) begin
        reads++;
        chk({tag, "_raddr"}, mem_addr_o, a);
      end
      if (mem_write_o) begin
        writes++;
        chk({tag, "_waddr"}, mem_addr_o, a);
        chk({tag, "_wdata"}, mem_wdata_o, ex_wword);
      end
      if (!mem_read_o && !mem_write_o) chk({tag, "_bus_idle"}, mem_addr_o | mem_wdata_o, 32'd0);
      if (done_o) got_done = 1'b1;
      else begin
        req_i = 1'($urandom); is_store_i = 1'($urandom); funct3_i = 3'($urandom);
        addr_i = $urandom_range(0, 31); wdata_i = $urandom;
      end
    end
    chk({tag, "_latency"}, n, lat);
    chk({tag, "_err"}, 32'(err_o), 32'(err));
    chk({tag, "_rdata"}, rdata_o, new_rdata);
    chk({tag, "_ready_busy"}, 32'(ready_o), 32'd0);
    chk({tag, "_reads"}, reads, ex_reads);
    chk({tag, "_writes"}, writes, ex_writes);
    chk_mem(tag);
    exp_rdata = new_rdata;
  endtask

  task automatic run(input bit st, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input int gap, input string tag);
    do_op(st, f3, a, wd, b2b_pending, tag);
    if (gap == 0) b2b_pending = 1'b1;
    else begin
      req_i = 1'b0;
      repeat (gap) @(negedge clk);
      b2b_pending = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cnt_done, cnt_wr, gap, sel;
    logic [31:0] a;

    for (int k = 0; k < MEM_BYTES; k++) init_mem[k] = 8'($urandom);
    {init_mem[3], init_mem[2], init_mem[1], init_mem[0]}    = 32'h00008080;
    {init_mem[11], init_mem[10], init_mem[9], init_mem[8]}  = 32'h11223344;
    for (int k = 0; k < MEM_BYTES; k++) ref_mem[k] = init_mem[k];
    load_mem = 1'b1;
    reset    = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    load_mem = 1'b0;
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_bus", mem_addr_o | mem_wdata_o, 32'd0);
    chk("rst_en", 32'({mem_read_o, mem_write_o}), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run(1, 3'd2, 32'd4, 32'hDEADBEEF, 1, "sw4");
    run(0, 3'd2, 32'd4, 32'h0, 0, "lw4");
    run(1, 3'd0, 32'd8, 32'hFFFFFFAA, 0, "sb8");
    run(0, 3'd2, 32'd8, 32'h0, 1, "lw8");
    run(0, 3'd0, 32'd0, 32'h0, 0, "lb0");
    run(0, 3'd4, 32'd0, 32'h0, 0, "lbu0");
    run(0, 3'd1, 32'd0, 32'h0, 2, "lh0");
    run(0, 3'd5, 32'd0, 32'h0, 0, "lhu0");
    run(0, 3'd2, 32'd29, 32'h0, 1, "lw29");
    run(1, 3'd2, 32'hFFFFFFFE, 32'h12345678, 0, "sw_wrap");
    run(0, 3'd3, 32'd4, 32'h0, 0, "ld_f3_011");
    run(1, 3'd4, 32'd4, 32'h0, 1, "st_f3_100");
    run(0, 3'd2, 32'd28, 32'h0, 0, "lw28");
    run(1, 3'd1, 32'd5, 32'hCAFEBABE, 0, "sh5");
    run(0, 3'd2, 32'd5, 32'h0, 1, "lw5");

    // sh accepted then reset during READ: aborted with no write and no done.
    is_store_i = 1'b1; funct3_i = 3'd1; addr_i = 32'd12; wdata_i = 32'hA5A5A5A5; req_i = 1'b1;
    @(posedge clk);
    #1;
    req_i = 1'b0;
    chk("abort_in_read", 32'(mem_read_o), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_ready", 32'(ready_o), 32'd1);
    chk("abort_en", 32'({mem_read_o, mem_write_o}), 32'd0);
    chk("abort_done_err", 32'({done_o, err_o}), 32'd0);
    chk("abort_rdata", rdata_o, 32'd0);
    chk("abort_bus", mem_addr_o | mem_wdata_o, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cnt_done = 0; cnt_wr = 0;
    repeat (4) begin
      @(negedge clk);
      if (done_o) cnt_done++;
      if (mem_write_o) cnt_wr++;
    end
    chk("abort_no_done", cnt_done, 32'd0);
    chk("abort_no_write", cnt_wr, 32'd0);
    chk_mem("abort");
    exp_rdata   = 32'h0;
    b2b_pending = 1'b0;

    for (int i = 0; i < 80; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 8) a = $urandom_range(0, 31);
      else if (sel == 8) a = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
      else a = $urandom;
      gap = (i == 79) ? 1 : $urandom_range(0, 2);
      run(1'($urandom), 3'($urandom), a, $urandom, gap, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
